y86_execute_stage: RTL and testbench

- Execute stage of the Y86-64 processor: ALU, condition-code (CC) register and branch/cmov condition evaluation.
- Sits between decode/register-file (supplies valA, valB) and memory/PC-update (consume valE, cnd).
- Result paths (valE, cnd) are combinational; the CC register updates on the clock edge.

---
 rtl/y86_pkg.sv | 38 +++
 rtl/y86_execute_stage_alu.sv | 37 +++
 rtl/y86_execute_stage.sv | 94 +++++++++
 tb/tb_y86_execute_stage.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 execute-stage constants: instruction codes, ALU functions,
// branch/cmov condition codes and the default datapath width.
package y86_pkg;

  localparam int DATA_W_DEFAULT = 64;
  localparam int STACK_STEP     = 8;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_XOR = 4'h3;

  localparam logic [3:0] C_YES = 4'h0;
  localparam logic [3:0] C_LE  = 4'h1;
  localparam logic [3:0] C_L   = 4'h2;
  localparam logic [3:0] C_E   = 4'h3;
  localparam logic [3:0] C_NE  = 4'h4;
  localparam logic [3:0] C_GE  = 4'h5;
  localparam logic [3:0] C_G   = 4'h6;

  function automatic logic is_alu_op(input logic [3:0] f);
    return (f <= ALU_XOR);
  endfunction

endpackage

// File: rtl/y86_execute_stage_alu.sv
// Combinational OPq ALU: result = b <op> a plus the flags it would produce.
// Unknown op codes give a zero result and clear flags-of-interest.
module y86_alu
  import y86_pkg::*;
#(
  parameter int W = DATA_W_DEFAULT
) (
  input  logic [3:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] result,
  output logic         zf,
  output logic         sf,
  output logic         of
);

  always_comb begin
    result = '0;
    of     = 1'b0;
    case (op)
      ALU_ADD: begin
        result = b + a;
        of     = (a[W-1] == b[W-1]) && (result[W-1] != a[W-1]);
      end
      ALU_SUB: begin
        result = b - a;
        of     = (a[W-1] != b[W-1]) && (result[W-1] != b[W-1]);
      end
      ALU_AND: result = b & a;
      ALU_XOR: result = b ^ a;
      default: result = '0;
    endcase
    zf = (result == '0);
    sf = result[W-1];
  end

endmodule

// File: rtl/y86_execute_stage.sv
// Y86-64 execute stage: valE mux around the OPq ALU, CC register and cnd logic.
// Build option EXEC_SETCC_GATE_EN adds set_cc_en to qualify CC writes.
module y86_execute_stage
  import y86_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        icode,
  input  logic [3:0]        ifun,
  input  logic [DATA_W-1:0] valA,
  input  logic [DATA_W-1:0] valB,
  input  logic [DATA_W-1:0] valC,
  output logic [DATA_W-1:0] valE,
  output logic              zf,
  output logic              sf,
  output logic              of,
  output logic              cnd
`ifdef EXEC_SETCC_GATE_EN
  ,
  input  logic              set_cc_en
`endif
);

  localparam logic [DATA_W-1:0] STEP = DATA_W'(STACK_STEP);

  logic [DATA_W-1:0] alu_result;
  logic              alu_zf, alu_sf, alu_of;
  logic              cc_we;
  logic              s_flag;

  y86_alu #(.W(DATA_W)) u_alu (
    .op     (ifun),
    .a      (valA),
    .b      (valB),
    .result (alu_result),
    .zf     (alu_zf),
    .sf     (alu_sf),
    .of     (alu_of)
  );

  always_comb begin
    valE = '0;
    case (icode)
      I_RRMOVQ:          valE = valA;
      I_IRMOVQ:          valE = valC;
      I_RMMOVQ, I_MRMOVQ: valE = valB + valC;
      I_OPQ:             valE = alu_result;
      I_CALL, I_PUSHQ:   valE = valB - STEP;
      I_RET, I_POPQ:     valE = valB + STEP;
      default:           valE = '0;
    endcase
  end

`ifdef EXEC_SETCC_GATE_EN
  assign cc_we = (icode == I_OPQ) && is_alu_op(ifun) && set_cc_en;
`else
  assign cc_we = (icode == I_OPQ) && is_alu_op(ifun);
`endif

  // Reset wins over a same-cycle OPq write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zf <= 1'b1;
      sf <= 1'b0;
      of <= 1'b0;
    end else if (cc_we) begin
      zf <= alu_zf;
      sf <= alu_sf;
      of <= alu_of;
    end
  end

  // cnd reads the registered flags, so an OPq in flight does not affect it.
  assign s_flag = sf ^ of;

  always_comb begin
    cnd = 1'b0;
    if (icode == I_RRMOVQ || icode == I_JXX) begin
      case (ifun)
        C_YES:   cnd = 1'b1;
        C_LE:    cnd = s_flag | zf;
        C_L:     cnd = s_flag;
        C_E:     cnd = zf;
        C_NE:    cnd = ~zf;
        C_GE:    cnd = ~s_flag;
        C_G:     cnd = ~s_flag & ~zf;
        default: cnd = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_y86_execute_stage.sv
// Scoreboard bench for y86_execute_stage: directed cases plus random ops,
// with an independent reference model of valE, cnd and the CC register.
module tb_y86_execute_stage;

  logic        clk;
  logic        rst_n;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic [63:0] valA, valB, valC;
  logic [63:0] valE;
  logic        zf, sf, of, cnd;
  logic        set_cc_en;

  logic [63:0] exp_q[$];
  int          n_checks;
  int          n_errors;

  logic        m_zf, m_sf, m_of;

  y86_execute_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .icode (icode),
    .ifun  (ifun),
    .valA  (valA),
    .valB  (valB),
    .valC  (valC),
    .valE  (valE),
    .zf    (zf),
    .sf    (sf),
    .of    (of),
    .cnd   (cnd)
`ifdef EXEC_SETCC_GATE_EN
    ,
    .set_cc_en (set_cc_en)
`endif
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // reference model
  function automatic logic [63:0] m_vale(input logic [3:0] i, input logic [3:0] f,
                                         input logic [63:0] a, input logic [63:0] b,
                                         input logic [63:0] c);
    case (i)
      4'h2: return a;
      4'h3: return c;
      4'h4, 4'h5: return b + c;
      4'h6: begin
        case (f)
          4'h0: return b + a;
          4'h1: return b - a;
          4'h2: return b & a;
          4'h3: return b ^ a;
          default: return 64'd0;
        endcase
      end
      4'h8, 4'hA: return b - 64'd8;
      4'h9, 4'hB: return b + 64'd8;
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic m_cnd(input logic [3:0] i, input logic [3:0] f);
    logic s;
    s = m_sf ^ m_of;
    if (i != 4'h2 && i != 4'h7) return 1'b0;
    case (f)
      4'h0: return 1'b1;
      4'h1: return s | m_zf;
      4'h2: return s;
      4'h3: return m_zf;
      4'h4: return !m_zf;
      4'h5: return !s;
      4'h6: return !s && !m_zf;
      default: return 1'b0;
    endcase
  endfunction

  task automatic push_flags();
    exp_q.push_back({63'd0, m_zf});
    exp_q.push_back({63'd0, m_sf});
    exp_q.push_back({63'd0, m_of});
  endtask

  task automatic check_flags(input string tag);
    check({tag, ".zf"}, {63'd0, zf}, exp_q.pop_front());
    check({tag, ".sf"}, {63'd0, sf}, exp_q.pop_front());
    check({tag, ".of"}, {63'd0, of}, exp_q.pop_front());
  endtask

  // driver: one instruction, check combinational results, clock, check CC
  task automatic do_op(input string tag, input logic [3:0] i, input logic [3:0] f,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] c, input logic en);
    logic [64:0] wide;
    logic [63:0] r;
    logic        upd;
    @(negedge clk);
    icode = i; ifun = f; valA = a; valB = b; valC = c; set_cc_en = en;
    r = m_vale(i, f, a, b, c);
    exp_q.push_back(r);
    exp_q.push_back({63'd0, m_cnd(i, f)});
    #1;
    check({tag, ".valE"}, valE, exp_q.pop_front());
    check({tag, ".cnd"}, {63'd0, cnd}, exp_q.pop_front());
    upd = (i == 4'h6) && (f <= 4'h3) && en;
    @(posedge clk);
    if (upd) begin
      m_zf = (r == 64'd0);
      m_sf = r[63];
      case (f)
        4'h0: begin wide = {a[63], a} + {b[63], b}; m_of = wide[64] ^ wide[63]; end
        4'h1: begin wide = {b[63], b} - {a[63], a}; m_of = wide[64] ^ wide[63]; end
        default: m_of = 1'b0;
      endcase
    end
    #1;
    push_flags();
    check_flags(tag);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    icode = 4'h7; ifun = 4'h3;
    valA = '0; valB = '0; valC = '0;
    set_cc_en = 1'b1;
    m_zf = 1'b1; m_sf = 1'b0; m_of = 1'b0;

    #12;
    push_flags();
    check_flags("reset");
    exp_q.push_back(64'd1);
    check("reset.cnd_je", {63'd0, cnd}, exp_q.pop_front());
    @(negedge clk);
    rst_n = 1'b1;

    do_op("add_ovf", 4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 1'b1);
    do_op("jl_after_ovf", 4'h7, 4'h2, 64'd0, 64'd0, 64'd0, 1'b1);
    do_op("irmovq_hold", 4'h3, 4'h0, 64'd3, 64'd4, 64'd0, 1'b1);
    do_op("opq_bad_ifun", 4'h6, 4'h5, 64'd1, 64'd2, 64'd0, 1'b1);
    do_op("sub_zero", 4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 1'b1);
    do_op("cmovle", 4'h2, 4'h1, 64'hDEAD_BEEF, 64'd9, 64'd0, 1'b1);
    do_op("pushq", 4'hA, 4'h0, 64'd0, 64'h100, 64'd0, 1'b1);
    do_op("popq", 4'hB, 4'h0, 64'd0, 64'h100, 64'd0, 1'b1);
    do_op("mrmovq", 4'h5, 4'h0, 64'd0, 64'h20, 64'h10, 1'b1);
    do_op("call_wrap", 4'h8, 4'h0, 64'd0, 64'd4, 64'd0, 1'b1);
    do_op("sub_neg_ovf", 4'h6, 4'h1, 64'd1, 64'h8000_0000_0000_0000, 64'd0, 1'b1);
    do_op("jg_after", 4'h7, 4'h6, 64'd0, 64'd0, 64'd0, 1'b1);
    do_op("jge_after", 4'h7, 4'h5, 64'd0, 64'd0, 64'd0, 1'b1);
    do_op("halt", 4'h0, 4'h0, 64'd1, 64'd2, 64'd3, 1'b1);
    do_op("icode_f", 4'hF, 4'h0, 64'd1, 64'd2, 64'd3, 1'b1);

`ifdef EXEC_SETCC_GATE_EN
    do_op("nz_setup", 4'h6, 4'h0, 64'd1, 64'd1, 64'd0, 1'b1);
    do_op("xor_gated", 4'h6, 4'h3, 64'd7, 64'd7, 64'd0, 1'b0);
    do_op("xor_enabled", 4'h6, 4'h3, 64'd7, 64'd7, 64'd0, 1'b1);
`endif

    for (int k = 0; k < 60; k++) begin
      logic [3:0]  ri, rf;
      logic [63:0] ra, rb, rc;
      ri = 4'($urandom_range(0, 15));
      rf = (ri == 4'h6) ? 4'($urandom_range(0, 4)) : 4'($urandom_range(0, 15));
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rc = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) ra = rb;
      do_op("rand", ri, rf, ra, rb, rc, 1'b1);
    end

    do_op("pre_reset_nz", 4'h6, 4'h0, 64'd1, 64'hFFFF_FFFF_FFFF_FFF0, 64'd0, 1'b1);
    @(negedge clk);
    icode = 4'h6; ifun = 4'h0; valA = 64'd1; valB = 64'd1;
    #2;
    rst_n = 1'b0;
    m_zf = 1'b1; m_sf = 1'b0; m_of = 1'b0;
    #1;
    push_flags();
    check_flags("async_reset");
    @(posedge clk);
    #1;
    push_flags();
    check_flags("reset_over_update");
    @(negedge clk);
    rst_n = 1'b1;
    do_op("post_reset_add", 4'h6, 4'h0, 64'd2, 64'd3, 64'd0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
